// File: rtl/nam85_pkg.sv
// nam85_pkg: shared serializer state encoding and default output-port constants
package nam85_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/out_fifo.sv
// out_fifo: byte FIFO with a head peek; a pop frees a slot for a same-cycle push when full
module out_fifo import nam85_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    // storage array needs no reset; stale entries are never read while empty
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/out_port.sv
// out_port: buffered UART-style byte transmitter (8N1); define OUT_PORT_PARITY_EN for an even parity bit
module out_port import nam85_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               data_in,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    state_t state;
    logic [BW-1:0] baud;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, head;
    logic pop, bit_end;
`ifdef OUT_PORT_PARITY_EN
    logic par;
`endif
    assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
    assign pop = !empty && (state == IDLE || (state == STOP && bit_end));

    out_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(wr_en),
        .pop(pop),
        .din(data_in),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    // a push is lost only when full and no slot is freed on the same edge
    always_ff @(posedge clk) begin
        if (rst) overflow <= 1'b0;
        else if (wr_en && full && !pop) overflow <= 1'b1;
    end

    // serializer: loading a byte always starts a fresh start bit, from IDLE or from the last STOP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            baud <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            busy <= 1'b0;
            tx <= IDLE_LEVEL;
`ifdef OUT_PORT_PARITY_EN
            par <= 1'b0;
`endif
        end else if (pop) begin
            shreg <= head;
            bit_cnt <= '0;
            baud <= '0;
            state <= START;
            busy <= 1'b1;
            tx <= ~IDLE_LEVEL;
`ifdef OUT_PORT_PARITY_EN
            par <= ^head;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx <= IDLE_LEVEL;
                end
                START: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        state <= DATA;
                        tx <= shreg[0];
                    end
                end
                DATA: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
`ifdef OUT_PORT_PARITY_EN
                            state <= PARITY;
                            tx <= par;
`else
                            state <= STOP;
                            tx <= IDLE_LEVEL;
`endif
                        end else begin
                            tx <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        state <= STOP;
                        tx <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        tx <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    tx <= IDLE_LEVEL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_out_port.sv
// tb_out_port: scoreboard bench for out_port with a frame-level reference model and a line monitor
module tb_out_port;
    localparam int DEPTH = 4;
    localparam int CPB = 4;
    localparam int HALF = CPB / 2;
`ifdef OUT_PORT_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic full, empty, overflow, busy, tx;
    logic [$clog2(DEPTH):0] count;

    out_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .data_in(data_in),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .busy(busy),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    byte unsigned m_q[$];
    byte unsigned exp_q[$];
    int m_timer = 0;
    bit m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // one clock: drive inputs, advance the model on the edge, compare after the edge
    task automatic cycle(input bit r, input bit w, input byte unsigned d);
        bit p, acc;
        rst = r;
        wr_en = w;
        data_in = d;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_timer = 0;
            m_ovf = 1'b0;
        end else begin
            p = m_q.size() > 0 && m_timer <= 1;
            acc = w && (m_q.size() < DEPTH || p);
            if (p) begin
                exp_q.push_back(m_q.pop_front());
                m_timer = FRAME;
            end else if (m_timer > 0) begin
                m_timer--;
            end
            if (acc) m_q.push_back(d);
            else if (w) m_ovf = 1'b1;
        end
        #1;
        chk("count", int'(count), m_q.size());
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'(m_timer != 0));
        if (m_timer == 0) chk("idle_tx", int'(tx), 1);
        data_in = 8'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (m_q.size() > 0 || m_timer > 0); k++) cycle(0, 0, 0);
        chk("drain_timeout", m_timer + m_q.size(), 0);
        repeat (2) cycle(0, 0, 0);
    endtask

    // line monitor: rebuilds each frame from tx samples and checks it against the scoreboard
    bit mon_on = 1'b0;
    int mon_cnt = 0;
    logic [7:0] mon_byte;
    logic mon_par;
    always @(negedge clk) begin
        if (rst) begin
            mon_on = 1'b0;
        end else begin
            if (!mon_on && tx === 1'b0) begin
                mon_on = 1'b1;
                mon_cnt = 0;
                mon_byte = 8'h00;
                mon_par = 1'b0;
            end
            if (mon_on) begin
                if (mon_cnt == HALF) chk("start_bit", int'(tx), 0);
                for (int i = 0; i < 8; i++) if (mon_cnt == CPB * (i + 1) + HALF) mon_byte[i] = tx;
                if (mon_cnt == CPB * 9 + HALF) mon_par = tx;
                if (mon_cnt == FRAME - CPB + HALF) chk("stop_bit", int'(tx), 1);
                if (mon_cnt == FRAME - 1) begin
                    mon_on = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got byte %0d expected no frame at %0t", mon_byte, $time);
                    end else begin
                        byte unsigned e;
                        e = exp_q.pop_front();
                        chk("frame_data", int'(mon_byte), int'(e));
`ifdef OUT_PORT_PARITY_EN
                        chk("parity_bit", int'(mon_par), int'(^e));
`endif
                    end
                end
                mon_cnt++;
            end
        end
    end

    initial begin
        repeat (2) cycle(1, 0, 0);
        chk("reset_tx", int'(tx), 1);
        chk("reset_count", int'(count), 0);
        cycle(0, 1, 8'hA5);
        cycle(0, 0, 0);
        chk("latency_tx_low", int'(tx), 0);
        repeat (FRAME + 5) cycle(0, 0, 0);
        chk("single_empty", int'(empty), 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'($urandom));
        chk("burst_overflow", int'(overflow), 1);
        drain();
        cycle(1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h10 + i));
        chk("fill_full", int'(full), 1);
        for (int k = 0; k < 200 && m_timer != 1; k++) cycle(0, 0, 0);
        chk("stop_end_reached", m_timer, 1);
        cycle(0, 1, 8'h3C);
        chk("coincide_count", int'(count), 4);
        chk("coincide_ovf", int'(overflow), 0);
        drain();
        cycle(0, 1, 8'h11);
        cycle(0, 1, 8'h22);
        cycle(0, 1, 8'h33);
        repeat (CPB * 3) cycle(0, 0, 0);
        cycle(1, 1, 8'h44);
        chk("abort_tx", int'(tx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        repeat (FRAME * 2) cycle(0, 0, 0);
        cycle(0, 1, 8'h00);
        cycle(0, 1, 8'hFF);
        drain();
        cycle(0, 1, 8'h07);
        cycle(0, 1, 8'h03);
        drain();
        repeat (1500) cycle($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
        drain();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/out_port.md
OUT_PORT -- requirements
Module: out_port

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter CLKS_PER_BIT, 4, clk cycles per serial bit (>=2).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock (CPU clk_out domain); all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  output strobe from controller (output_alu); push request.
REQ-007 data_in  input  8  byte to output (ALU result).
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 empty  output  1  FIFO holds 0 entries.
REQ-010 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky: a push was dropped.
REQ-012 busy  output  1  serializer not IDLE.
REQ-013 tx  output  1  serial line, idle high.

Function
REQ-014 Push: wr_en=1 and (not full, or pop in same cycle) SHALL store data_in at tail; count+1 unless simultaneous pop.
REQ-015 wr_en=1 while full with no same-cycle pop SHALL drop the byte and set overflow; FIFO unchanged.
REQ-016 Pop SHALL occur only when FIFO non-empty before the edge; no write-to-pop bypass on an empty FIFO.
REQ-017 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-018 Serializer FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY per REQ-029).
REQ-019 IDLE: if non-empty, pop head into shift register, bit counter=0, go START; else stay, tx=1.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP (or PARITY).
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; on final cycle, if non-empty, pop and go directly START (no gap), else IDLE.
REQ-023 Latency: push at edge N into empty FIFO with FSM IDLE SHALL produce tx=0 after edge N+1.
REQ-024 Frame length SHALL be 10*CLKS_PER_BIT cycles (11* with parity).
REQ-025 busy SHALL equal (state != IDLE); tx SHALL be registered (glitch-free).
REQ-026 data_in changes after a push SHALL not affect stored or in-flight bytes.

Reset
REQ-027 rst=1 at an edge SHALL set: FIFO empty, count=0, full=0, empty=1, overflow=0, state IDLE, busy=0, tx=1, baud and bit counters 0.
REQ-028 Reset mid-frame SHALL abort the frame; tx=1 from the next cycle; pending bytes discarded; wr_en during rst ignored.

Configuration
REQ-029 Macro OUT_PORT_PARITY_EN defined: PARITY state between DATA and STOP drives even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; undefined: no PARITY state, DATA goes directly to STOP, frame per REQ-024 base length.

Structure
REQ-030 Shared package nam85_pkg SHALL hold the FSM state enum, default DEPTH/CLKS_PER_BIT constants, and idle-line level constant.
REQ-031 FIFO SHALL be a sub-module out_fifo (push/pop/full/empty/count); FSM and shifter stay in out_port.

Verification (DEPTH=4, CLKS_PER_BIT=4)
REQ-032 Reset then single push 0xA5 -> tx low after next edge, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high; busy=1 for 40 cycles; empty=1 at end.
REQ-033 Push 6 bytes on consecutive cycles while idle -> first popped, 4 buffered, 1 dropped; overflow=1 stays set; 5 frames back-to-back with no idle gap between.
REQ-034 FIFO full and push coincides with STOP-end pop -> push accepted, count stays 4, overflow stays 0.
REQ-035 Assert rst mid-DATA with 2 bytes queued -> next cycle tx=1, busy=0, count=0, overflow=0; no further frames.
REQ-036 With OUT_PORT_PARITY_EN, push 0x07 -> parity bit 1, frame 44 cycles; push 0x03 -> parity bit 0.
REQ-037 Push 0x00 then 0xFF -> line data bits all 0 then all 1; count 0->1->... tracks pushes/pops exactly.
